// File: rtl/div_pkg.sv
// Shared types and constants for the non-restoring sequential divider.
// Contents:
//   div_state_e  - controller states (IDLE, RUN, FIX, DONE)
//   DIV_ZERO_Q   - quotient reported on divide-by-zero (all ones, slice to width)
//   div_cnt_w()  - iteration counter width, $clog2(N) with a floor of 1
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int unsigned DIV_MAX_W = 64;

    // Slice [N-1:0] at the use site.
    localparam logic [DIV_MAX_W-1:0] DIV_ZERO_Q = '1;

    // Counter counts 0..N-1, so $clog2(N) bits suffice.
    function automatic int unsigned div_cnt_w(input int unsigned n);
        int unsigned w;
        w = 32'($clog2(n));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/add_sub_rca.sv
// W-bit ripple-carry adder/subtractor.
// Ports:
//   a_i   - first operand
//   b_i   - second operand
//   sub_i - 1: a_i - b_i (B inverted, carry-in 1); 0: a_i + b_i
//   sum_o - W-bit two's complement result, carry-out discarded
module add_sub_rca #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o
);

    logic [W-1:0] b_x;
    logic         carry;

    // Bit-serial carry chain; the final carry is not needed.
    always_comb begin
        b_x   = b_i ^ {W{sub_i}};
        carry = sub_i;
        sum_o = '0;
        for (int i = 0; i < int'(W); i++) begin
            sum_o[i] = a_i[i] ^ b_x[i] ^ carry;
            carry    = (a_i[i] & b_x[i]) | (carry & (a_i[i] ^ b_x[i]));
        end
    end

endmodule

// File: rtl/nonrestoring_div_seq.sv
// Iterative N-bit divider, non-restoring, one quotient bit per clock.
// Optional feature: define DIV_SIGNED_EN for two's complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Ports:
//   clk, rst_n     - rising-edge clock, synchronous active-low reset
//   start          - request; accepted only while ready=1
//   dividend       - numerator, sampled on accept
//   divisor        - denominator, sampled on accept
//   ready          - idle, can accept start
//   valid          - one-cycle pulse, results valid
//   quotient       - result quotient, held until next result
//   remainder      - result remainder, held until next result
//   div_by_zero    - divisor was zero; held with results
module nonrestoring_div_seq
    import div_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         valid,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CNT_W = div_cnt_w(N);

    div_state_e       state_q, state_d;
    logic [N:0]       p_q, p_d;
    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     quot_q, quot_d;
    logic [N-1:0]     rem_q, rem_d;
    logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
`endif

    logic [N:0]       as_a, as_b, as_sum;
    logic             as_sub;
    logic [N-1:0]     dvd_mag, dvs_mag;
    logic [N-1:0]     p_fix;

    // Operand magnitudes latched on accept.
`ifdef DIV_SIGNED_EN
    always_comb begin
        dvd_mag = dividend[N-1] ? (~dividend + N'(1)) : dividend;
        dvs_mag = divisor[N-1]  ? (~divisor  + N'(1)) : divisor;
    end
`else
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
    end
`endif

    // Single add/sub shared by RUN (shifted P +/- D) and FIX (P + D).
    always_comb begin
        as_b = {1'b0, d_q};
        if (state_q == RUN) begin
            as_a   = {p_q[N-1:0], q_q[N-1]};
            as_sub = ~p_q[N];
        end else begin
            as_a   = p_q;
            as_sub = 1'b0;
        end
    end

    add_sub_rca #(
        .W(N + 1)
    ) u_add_sub (
        .a_i   (as_a),
        .b_i   (as_b),
        .sub_i (as_sub),
        .sum_o (as_sum)
    );

    // Final remainder correction; corrected P is non-negative and < D.
    always_comb begin
        p_fix = p_q[N] ? as_sum[N-1:0] : p_q[N-1:0];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        q_d       = q_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d = dvs_mag;
                    if (divisor == '0) begin
                        quot_d  = DIV_ZERO_Q[N-1:0];
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        p_d     = '0;
                        q_d     = dvd_mag;
                        cnt_d   = '0;
                        state_d = RUN;
`ifdef DIV_SIGNED_EN
                        neg_quo_d = dividend[N-1] ^ divisor[N-1];
                        neg_rem_d = dividend[N-1];
`endif
                    end
                end
            end
            RUN: begin
                p_d   = as_sum;
                q_d   = {q_q[N-2:0], ~as_sum[N]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                p_d   = {1'b0, p_fix};
                dbz_d = 1'b0;
`ifdef DIV_SIGNED_EN
                quot_d = neg_quo_q ? (~q_q + N'(1)) : q_q;
                rem_d  = neg_rem_q ? (~p_fix + N'(1)) : p_fix;
`else
                quot_d = q_q;
                rem_d  = p_fix;
`endif
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            p_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            q_q       <= q_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign ready       = ready_q;
    assign valid       = valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_div_seq.sv
// Self-checking bench for nonrestoring_div_seq (N=8), scoreboard driven.
module tb_nonrestoring_div_seq;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         ready;
    logic         valid;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    nonrestoring_div_seq #(
        .N(N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         z;
        int unsigned  acc;
        int unsigned  lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   post_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic z);
`ifdef DIV_SIGNED_EN
        int sa;
        int sd;
`endif
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = $signed(a);
            sd = $signed(b);
            q  = N'(sa / sd);
            r  = N'(sa % sd);
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t        x;
        int unsigned guard;
        guard = 0;
        while (!ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_before_start", 32'(ready), 32'd1);
        model(a, b, x.q, x.r, x.z);
        x.acc    = cyc + 1;
        x.lat    = x.z ? 1 : N + 2;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned guard;
        guard = 0;
        while (sb.size() != 0 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
        @(negedge clk);
    endtask

    // Output monitor: pops the scoreboard on each valid pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (post_valid) begin
                post_valid = 1'b0;
                check_eq("ready_after_valid", 32'(ready), 32'd1);
                check_eq("valid_one_cycle", 32'(valid), 32'd0);
            end else if (valid) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_valid", 32'(valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("quotient", 32'(quotient), 32'(e.q));
                    check_eq("remainder", 32'(remainder), 32'(e.r));
                    check_eq("div_by_zero", 32'(div_by_zero), 32'(e.z));
                    check_eq("latency", cyc - e.acc + 1, e.lat);
                    post_valid = 1'b1;
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_quotient", 32'(quotient), 32'd0);
        check_eq("rst_remainder", 32'(remainder), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operands and boundaries.
        run_op(8'd100, 8'd7);  wait_drain();
        run_op(8'd255, 8'd1);  wait_drain();
        run_op(8'd5,   8'd9);  wait_drain();
        run_op(8'd255, 8'd255); wait_drain();
        run_op(8'd77,  8'd0);  wait_drain();

        // Start during RUN must be ignored.
        run_op(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (N + 4) @(negedge clk);

        // Reset at iteration 4 aborts the operation.
        run_op(8'd100, 8'd7);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        sb.delete();
        check_eq("abort_ready", 32'(ready), 32'd1);
        check_eq("abort_valid", 32'(valid), 32'd0);
        check_eq("abort_quotient", 32'(quotient), 32'd0);
        check_eq("abort_remainder", 32'(remainder), 32'd0);
        check_eq("abort_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        run_op(8'd100, 8'd7); wait_drain();

`ifdef DIV_SIGNED_EN
        run_op(8'hF9, 8'd2);  wait_drain();
        run_op(8'd7,  8'hFE); wait_drain();
        run_op(8'h80, 8'hFF); wait_drain();
        run_op(8'h80, 8'd0);  wait_drain();
`endif

        // Random operands, divisor zero occasionally.
        for (int i = 0; i < 10; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = N'($urandom_range(0, 255));
            rb = (i == 3) ? '0 : N'($urandom_range(1, 255));
            run_op(ra, rb);
            wait_drain();
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
